// File: rtl/ntt_pkg.sv
// Shared constants for the NTT stage sequencer: FSM encoding, mode values and
// default transform geometry.
package ntt_pkg;

    localparam int DEF_N        = 256;
    localparam int DEF_LOGN     = 8;
    localparam int DEF_PIPE_LAT = 5;

    typedef logic [1:0] ntt_state_t;

    localparam ntt_state_t ST_IDLE  = 2'd0;
    localparam ntt_state_t ST_RUN   = 2'd1;
    localparam ntt_state_t ST_DRAIN = 2'd2;
    localparam ntt_state_t ST_DONE  = 2'd3;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address generator: maps butterfly index j and
// log2 distance k to the two coefficient addresses and the twiddle address.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int LOGN = DEF_LOGN
) (
    input  logic [LOGN-2:0]         j,
    input  logic [$clog2(LOGN)-1:0] k,
    output logic [LOGN-1:0]         rd_addr_1,
    output logic [LOGN-1:0]         rd_addr_2,
    output logic [LOGN-1:0]         tw_addr
);

    localparam logic [LOGN-1:0] HALF_N = LOGN'(N / 2);

    logic [LOGN-1:0] jx, d, g, o;

    assign jx = {1'b0, j};
    assign d  = LOGN'(1) << k;
    assign g  = jx >> k;
    assign o  = jx & (d - 1'b1);

    // g*2d leaves the low k+1 bits clear and o < d, so OR is the same as add;
    // shifting twice keeps k+1 from overflowing the k width.
    assign rd_addr_1 = ((g << k) << 1) | o;
    assign rd_addr_2 = rd_addr_1 + d;
    assign tw_addr   = (HALF_N >> k) + g;

endmodule

// File: rtl/ntt_stage_ctrl.sv
// In-place radix-2 NTT/INTT stage sequencer: issues one butterfly per cycle,
// drains the datapath between stages and replays addresses for write-back.
module ntt_stage_ctrl
    import ntt_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int LOGN     = DEF_LOGN,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(LOGN)-1:0] stage,
    output logic                    rd_en,
    output logic [LOGN-1:0]         rd_addr_1,
    output logic [LOGN-1:0]         rd_addr_2,
    output logic [LOGN-1:0]         tw_addr,
    output logic                    bf_select,
    output logic                    wr_en,
    output logic [LOGN-1:0]         wr_addr_1,
    output logic [LOGN-1:0]         wr_addr_2
);

    localparam int SW = $clog2(LOGN);
    localparam int DW = $clog2(PIPE_LAT + 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LAT - 1);

    ntt_state_t      state;
    logic [LOGN-2:0] j;
    logic [DW-1:0]   dcnt;
    logic [SW-1:0]   k;
    logic [LOGN-1:0] gen_a1, gen_a2, gen_tw;

    logic [PIPE_LAT:1]           vld_pipe;
    logic [PIPE_LAT:1][LOGN-1:0] a1_pipe, a2_pipe;

    // NTT walks distance N/2 down to 1, INTT walks it back up.
    assign k = (bf_select == MODE_NTT) ? LAST_STAGE - stage : stage;

    ntt_addr_gen #(.N(N), .LOGN(LOGN)) u_addr_gen (
        .j         (j),
        .k         (k),
        .rd_addr_1 (gen_a1),
        .rd_addr_2 (gen_a2),
        .tw_addr   (gen_tw)
    );

    assign rd_en     = (state == ST_RUN);
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign rd_addr_1 = rd_en ? gen_a1 : '0;
    assign rd_addr_2 = rd_en ? gen_a2 : '0;
    assign tw_addr   = rd_en ? gen_tw : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            stage     <= '0;
            j         <= '0;
            dcnt      <= '0;
            bf_select <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state     <= ST_RUN;
                    bf_select <= mode;
                    stage     <= '0;
                    j         <= '0;
                end
                ST_RUN: begin
                    j <= j + 1'b1;
                    if (j == '1) begin
                        state <= ST_DRAIN;
                        dcnt  <= '0;
                    end
                end
                ST_DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    // Last write-back of the stage lands in this cycle; the
                    // next stage's first read relies on write-then-read RAM.
                    if (dcnt == LAST_DRAIN) begin
                        if (stage == LAST_STAGE) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                            stage <= stage + 1'b1;
                            j     <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a1_pipe  <= '0;
            a2_pipe  <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            a1_pipe[1]  <= rd_addr_1;
            a2_pipe[1]  <= rd_addr_2;
            for (int i = 2; i <= PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a1_pipe[i]  <= a1_pipe[i-1];
                a2_pipe[i]  <= a2_pipe[i-1];
            end
        end
    end

    assign wr_en     = vld_pipe[PIPE_LAT];
    assign wr_addr_1 = a1_pipe[PIPE_LAT];
    assign wr_addr_2 = a2_pipe[PIPE_LAT];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl at N=8: directed runs push expected
// reads/writes, a negedge monitor pops and compares them.
module tb_ntt_stage_ctrl;
    import ntt_pkg::*;

    localparam int N = 8, LOGN = 3, PL = 5, BUSY_CYC = 27;

    // Hand-computed NTT order (stage-major); INTT visits the stages reversed.
    localparam int EXP_A1 [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    localparam int EXP_A2 [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    localparam int EXP_TW [12] = '{1, 1, 1, 1,  2, 2, 3, 3,  4, 5, 6, 7};

    typedef struct packed { logic [2:0] a1, a2, tw; logic sel; } rd_exp_t;
    typedef struct packed { logic [2:0] a1, a2; } wr_exp_t;

    logic       clk = 1'b0;
    logic       rst, start, mode;
    logic       busy, done, rd_en, bf_select, wr_en;
    logic [1:0] stage;
    logic [2:0] rd_addr_1, rd_addr_2, tw_addr, wr_addr_1, wr_addr_2;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    int      rd_cyc_q[$];
    rd_exp_t re;
    wr_exp_t we;
    int      c0;
    int      checks = 0, errors = 0, cyc = 0, done_cnt = 0, exp_done = 0;
    logic    prev_rd = 1'b0;

    always #5 clk = ~clk;

    ntt_stage_ctrl #(.N(N), .LOGN(LOGN), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
        .stage(stage), .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .tw_addr(tw_addr), .bf_select(bf_select), .wr_en(wr_en),
        .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a read or write.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            if (rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    re = rd_q.pop_front();
                    chk("rd_addr_1", rd_addr_1, re.a1);
                    chk("rd_addr_2", rd_addr_2, re.a2);
                    chk("tw_addr", tw_addr, re.tw);
                    chk("bf_select", bf_select, re.sel);
                end
                rd_cyc_q.push_back(cyc);
                if (!prev_rd) chk("no_wr_on_first_rd", wr_en, 0);
            end
            if (wr_en) begin
                if (wr_q.size() == 0 || rd_cyc_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    we = wr_q.pop_front();
                    chk("wr_addr_1", wr_addr_1, we.a1);
                    chk("wr_addr_2", wr_addr_2, we.a2);
                    c0 = rd_cyc_q.pop_front();
                    chk("wr_latency", cyc - c0, PL);
                end
            end
            if (done) done_cnt++;
            prev_rd = rd_en;
        end
    end

    task automatic push_run(input logic m);
        rd_exp_t r;
        wr_exp_t w;
        int      idx;
        for (int s = 0; s < 3; s++) begin
            for (int jj = 0; jj < 4; jj++) begin
                idx   = m ? (2 - s) * 4 + jj : s * 4 + jj;
                r.a1  = 3'(EXP_A1[idx]);
                r.a2  = 3'(EXP_A2[idx]);
                r.tw  = 3'(EXP_TW[idx]);
                r.sel = m;
                w.a1  = r.a1;
                w.a2  = r.a2;
                rd_q.push_back(r);
                wr_q.push_back(w);
            end
        end
    endtask

    task automatic issue(input logic m);
        push_run(m);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle.
    task automatic do_run(input logic m, input bit mid_start, input bit toggle, input bit chained);
        int busy_n = 0;
        bit got    = 1'b0;
        if (!chained) issue(m);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (toggle) mode = ~mode;
            if (mid_start && c == 3) begin
                start = 1'b1;
                mode  = ~m;
            end
            if (mid_start && c == 4) start = 1'b0;
        end
        start = 1'b0;
        chk("busy_cycles", busy_n, BUSY_CYC);
        chk("done_seen", got, 1);
        chk("busy_at_done", busy, 0);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        if (got) exp_done++;
    endtask

    // Start raised in the DONE cycle and held into IDLE: only the IDLE one counts.
    task automatic chain_next(input logic m);
        push_run(m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        chk("idle_after_done_busy", busy, 0);
        chk("idle_after_done_done", done, 0);
        chk("single_done_pulse", done_cnt, exp_done);
        @(posedge clk); #1;
        start = 1'b0;
        do_run(m, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = MODE_NTT;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {busy, done, rd_en, wr_en, bf_select}, 0);
        chk("rst_stage", stage, 0);
        chk("rst_rd_addr", {rd_addr_1, rd_addr_2, tw_addr}, 0);
        chk("rst_wr_addr", {wr_addr_1, wr_addr_2}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_run(MODE_NTT, 1'b0, 1'b0, 1'b0);
        do_run(MODE_INTT, 1'b0, 1'b0, 1'b0);
        do_run(MODE_NTT, 1'b1, 1'b1, 1'b0);
        chain_next(MODE_INTT);

        // Reset while stage 1, j=2 is being issued.
        issue(MODE_NTT);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_q.delete();
        wr_q.delete();
        rd_cyc_q.delete();
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", rd_en, 0);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_done", done, 0);
        repeat (10) @(negedge clk);
        chk("midrst_no_done", done_cnt, exp_done);

        do_run(MODE_INTT, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("final_done_cnt", done_cnt, exp_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Sequencer for one radix-2 NTT/INTT butterfly core operating in place on an N-coefficient dual-port memory.
- On start, runs LOGN stages. Each stage issues one butterfly per cycle: two read addresses and a twiddle-ROM address.
- Drives the core's select line and generates write-back addresses delayed by the datapath latency.
- Sits between the top-level transform FSM, the coefficient RAM, the twiddle ROM and the butterfly core.

Parameters:
- N, 256, transform length (power of two, >= 4)
- LOGN, 8, log2(N); number of stages
- PIPE_LAT, 5, cycles from rd_en to the matching wr_en (RAM read + butterfly latency), >= 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- mode  in  1  0 = NTT, 1 = INTT; sampled when start is accepted
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after the final write-back
- stage  out  $clog2(LOGN)  current stage index
- rd_en  out  1  butterfly issue strobe
- rd_addr_1  out  LOGN  upper-leg coefficient address
- rd_addr_2  out  LOGN  lower-leg coefficient address
- tw_addr  out  LOGN  twiddle ROM address
- bf_select  out  1  to butterfly core select (0 NTT, 1 INTT)
- wr_en  out  1  write-back strobe
- wr_addr_1  out  LOGN  write address for output_1
- wr_addr_2  out  LOGN  write address for output_2

Behaviour:
- Reset: state IDLE; busy, done, rd_en and wr_en = 0; all pipeline valid bits cleared; all address outputs, stage and bf_select = 0.
- FSM states and transitions:
  - IDLE: start=1 -> RUN; latch mode into bf_select; stage=0; j=0.
  - RUN: rd_en=1 every cycle; j increments 0..N/2-1; at j=N/2-1 -> DRAIN; drain counter = 0.
  - DRAIN: rd_en=0 for exactly PIPE_LAT cycles. Then go to RUN with stage+1, j=0, or to DONE if stage=LOGN-1.
  - DONE: done=1 for one cycle, busy=0; -> IDLE.
- Butterfly distance:
  - NTT: d = 2^k with k = LOGN-1-stage (N/2 down to 1).
  - INTT: k = stage (1 up to N/2).
- Address generation, combinational from (j, k):
  - g = j >> k; o = j & (d-1).
  - rd_addr_1 = g*2d + o; rd_addr_2 = rd_addr_1 + d.
  - tw_addr = (N >> (k+1)) + g.
- Write-back:
  - rd_addr_1/2 and rd_en pass through a PIPE_LAT-deep shift register.
  - wr_en and wr_addr_1/2 equal the issue values exactly PIPE_LAT cycles later.
- Hazard rule: the last write of a stage lands in the last DRAIN cycle; the first read of the next stage is the following cycle. RAM write-then-read across the clock edge is required.
- Timing:
  - First rd_en occurs in the cycle after start is accepted.
  - busy lasts LOGN*(N/2+PIPE_LAT) cycles; done follows immediately.
- Boundary conditions:
  - start while busy or in DONE: ignored; mode is not re-sampled.
  - mode changes mid-run: no effect; bf_select stays constant for the whole run.
  - rst mid-operation: next cycle is IDLE with wr_en=0, so no in-flight write-back is issued; done is not pulsed.
  - Stage counter wrap: never exceeds LOGN-1.

Decomposition:
- Shared package ntt_pkg holds:
  - FSM state encoding (IDLE, RUN, DRAIN, DONE)
  - MODE_NTT/MODE_INTT constants
  - default N, LOGN, PIPE_LAT
- One sub-module: ntt_addr_gen, purely combinational: (j, k) -> rd_addr_1, rd_addr_2, tw_addr.
- Delay line and FSM stay in ntt_stage_ctrl.

Test Plan:
- N=8, LOGN=3, PIPE_LAT=5, NTT start:
  - stage0 pairs (0,4),(1,5),(2,6),(3,7), tw 1,1,1,1
  - stage1 pairs (0,2),(1,3),(4,6),(5,7), tw 2,2,3,3
  - stage2 pairs (0,1),(2,3),(4,5),(6,7), tw 4,5,6,7
  - busy high 27 cycles, then done pulse
- Same config, INTT: stage0 uses d=1 pairs, stage2 uses d=4 pairs (tw as per distance), bf_select=1 for the whole run, done after 27 busy cycles.
- Write alignment: every wr_en/wr_addr pair equals the rd_en/rd_addr pair from exactly 5 cycles earlier; no wr_en on the cycle of a stage's first read.
- start pulsed during RUN and again in the DONE cycle -> ignored, single done pulse; a start one cycle after done -> new run begins.
- rst asserted at stage1 j=2 -> next cycle busy=0, rd_en=0, wr_en=0, no done; a subsequent start runs a full 27-cycle transform.
- mode toggled every cycle during a run -> bf_select unchanged from the value sampled at start.
